// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver feeding a first-word-fall-through
// scan-code FIFO. Synchronises and deglitches the PS/2 lines, deserialises
// 11-bit frames, checks start/odd parity/stop, aborts stalled frames on a
// watchdog and reports errors as pulses plus sticky status.
// Optional feature macro: PS2_BREAK_TAG_EN (swallow 0xF0 and tag the next
// good byte with bit 8 set).
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
`ifdef PS2_BREAK_TAG_EN
    localparam int DW = 9,
`else
    localparam int DW = 8,
`endif
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kbd_clk,
    input  logic          kbd_data,
    input  logic          rd_en,
    input  logic          clr_err,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic [3:0]    err_pulse,
    output logic [3:0]    err_status
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   sclk, sdata;
    logic                   fclk, fall;
    logic [FW-1:0]          filt_cnt;
    logic [1:0]             state;
    logic [3:0]             bit_cnt;
    logic [9:0]             sr;
    logic [WW-1:0]          wd;
    logic                   timeout, frame_err, par_err, good;
    logic                   push, pop, wr_ok, ovf;
    logic [DW-1:0]          wdata;
    logic [DW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [DW-1:0]          rd_hold;

    assign sclk  = clk_sync[SYNC_STAGES-1];
    assign sdata = data_sync[SYNC_STAGES-1];

    // Metastability synchronisers; idle PS/2 lines are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kbd_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], kbd_data};
        end
    end

    // Glitch filter: fclk follows sclk only after FILTER_LEN consecutive
    // differing samples; a 1->0 transition produces a one-cycle fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fclk     <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sclk == fclk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                fclk     <= sclk;
                filt_cnt <= '0;
                fall     <= ~sclk;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign timeout = (state == S_SHIFT) && !fall && (wd == WW'(TIMEOUT_CYCLES - 1));

    // Frame FSM, shift register (LSB first: 8 data, parity, stop) and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            sr      <= '0;
            wd      <= '0;
        end else begin
            if (fall || state != S_SHIFT || timeout) wd <= '0;
            else                                     wd <= wd + 1'b1;
            case (state)
                S_IDLE: begin
                    if (fall && !sdata) begin
                        state   <= S_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (timeout) begin
                        state <= S_IDLE;
                    end else if (fall) begin
                        sr      <= {sdata, sr[9:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9) state <= S_CHECK;
                    end
                end
                S_CHECK: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stop-bit error takes precedence over parity error.
    assign frame_err = (state == S_CHECK) && !sr[9];
    assign par_err   = (state == S_CHECK) &&  sr[9] && !(^sr[8:0]);
    assign good      = (state == S_CHECK) &&  sr[9] &&  (^sr[8:0]);

`ifdef PS2_BREAK_TAG_EN
    logic brk;
    logic is_brk;
    assign is_brk = (sr[7:0] == 8'hF0) && !brk;
    assign push   = good && !is_brk;
    assign wdata  = {brk, sr[7:0]};

    // Break prefix flag: armed by a lone 0xF0, consumed by the next good byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                brk <= 1'b0;
        else if (frame_err || par_err || timeout) brk <= 1'b0;
        else if (good)                          brk <= is_brk;
    end
`else
    assign push  = good;
    assign wdata = sr[7:0];
`endif

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = rd_en && !empty;
    assign wr_ok = push && (!full || pop);
    assign ovf   = push && full && !pop;

    assign err_pulse = {timeout, ovf, frame_err, par_err};

    // Storage array; contents are only observed when occupied, so no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Remembers the last presented head so rd_data holds once drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rd_hold <= '0;
        else if (!empty) rd_hold <= mem[rd_ptr];
    end

    assign rd_data = empty ? rd_hold : mem[rd_ptr];

    // Sticky error status; a new pulse beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_status <= '0;
        else     err_status <= (clr_err ? 4'b0000 : err_status) | err_pulse;
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: scoreboard bench for ps2_rx_fifo. Stimulus pushes expected
// scan codes / error pulses into queues; a negedge monitor pops and compares
// whenever the DUT pops an entry or raises an error pulse.
module tb_ps2_rx_fifo;
    localparam int DEPTH = 4;
    localparam int TO    = 300;
    localparam int HALF  = 20;
`ifdef PS2_BREAK_TAG_EN
    localparam int DW = 9;
`else
    localparam int DW = 8;
`endif

    logic          clk = 0, rst = 1, kbd_clk = 1, kbd_data = 1, rd_en = 0, clr_err = 0;
    logic [DW-1:0] rd_data;
    logic          empty, full;
    logic [2:0]    count;
    logic [3:0]    err_pulse, err_status;

    int n_cmp = 0, n_bad = 0;
    logic [8:0] exp_data[$];
    logic [3:0] exp_err[$];

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .kbd_clk(kbd_clk), .kbd_data(kbd_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .err_pulse(err_pulse), .err_status(err_status));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first nbits of a frame: start, 8 data LSB first, parity, stop.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kbd_data = f[i];
            ticks(HALF);
            kbd_clk = 0;
            ticks(HALF);
            kbd_clk = 1;
        end
        kbd_data = 1;
        ticks(3 * HALF);
    endtask

    task automatic good(input logic [7:0] b);
        exp_data.push_back({1'b0, b});
        send_frame(b, 0, 0, 11);
    endtask

    task automatic pop1;
        rd_en = 1;
        ticks(1);
        rd_en = 0;
    endtask

    task automatic clr;
        clr_err = 1;
        ticks(1);
        clr_err = 0;
    endtask

    // Monitor: compare every popped head and every error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en && !empty) begin
                if (exp_data.size() == 0) check("unexpected_read", int'(rd_data), -1);
                else check("rd_data", int'(rd_data), int'(exp_data.pop_front()));
            end
            if (err_pulse != 4'b0000) begin
                if (exp_err.size() == 0) check("unexpected_err", int'(err_pulse), 0);
                else check("err_pulse", int'(err_pulse), int'(exp_err.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        ticks(3);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_status", err_status, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_rd_data", int'(rd_data), 0);
        rst = 0;
        ticks(5);

        // good frame
        good(8'h53);
        check("t1_count", count, 1);
        check("t1_empty", empty, 0);
        check("t1_head", int'(rd_data), 'h53);
        check("t1_status", err_status, 0);
        pop1;
        check("t1_empty_after", empty, 1);

        // parity error
        exp_err.push_back(4'b0001);
        send_frame(8'h53, 1, 0, 11);
        check("t2_empty", empty, 1);
        check("t2_status", err_status, 4'b0001);
        clr;
        check("t2_clr", err_status, 0);

        // frame error then good frame
        exp_err.push_back(4'b0010);
        send_frame(8'h53, 0, 1, 11);
        good(8'h1C);
        check("t3_head", int'(rd_data), 'h1C);
        pop1;
        clr;

        // watchdog
        exp_err.push_back(4'b1000);
        send_frame(8'hA5, 0, 0, 5);
        ticks(TO + 10);
        check("t4_status", err_status, 4'b1000);
        check("t4_empty", empty, 1);
        clr;
        good(8'h29);
        check("t4_count", count, 1);
        pop1;

        // reset mid-frame
        send_frame(8'hAA, 0, 0, 4);
        rst = 1;
        ticks(2);
        check("midrst_count", count, 0);
        rst = 0;
        ticks(2);
        good(8'h5A);
        check("midrst_head", int'(rd_data), 'h5A);
        pop1;

        // overflow
        for (int i = 0; i < DEPTH; i++) good(8'(i));
        check("t5_full", full, 1);
        exp_err.push_back(4'b0100);
        send_frame(8'(DEPTH), 0, 0, 11);
        check("t5_full2", full, 1);
        check("t5_count", count, DEPTH);
        check("t5_status", err_status, 4'b0100);
        repeat (DEPTH) pop1;
        check("t5_empty", empty, 1);
        clr;

        // push and pop together while full
        for (int i = 0; i < DEPTH; i++) good(8'(8'h20 + i));
        exp_data.push_back(9'(8'h20 + DEPTH));
        fork
            send_frame(8'(8'h20 + DEPTH), 0, 0, 11);
            begin
                int nf = 0;
                int cyc = 0;
                while (nf < 11 && cyc < 1000) begin
                    @(negedge clk);
                    cyc++;
                    if (dut.fall) nf++;
                end
                check("t6_falls_seen", nf, 11);
                @(posedge clk); #1 rd_en = 1;
                @(posedge clk); #1 rd_en = 0;
            end
        join
        check("t6_count", count, DEPTH);
        check("t6_full", full, 1);
        check("t6_status", err_status, 0);
        repeat (DEPTH) pop1;
        check("t6_empty", empty, 1);

`ifdef PS2_BREAK_TAG_EN
        exp_data.push_back(9'h11C);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h1C, 0, 0, 11);
        check("brk_count", count, 1);
        pop1;
        exp_err.push_back(4'b0001);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h33, 1, 0, 11);
        exp_data.push_back(9'h01C);
        send_frame(8'h1C, 0, 0, 11);
        check("brk_clr_count", count, 1);
        pop1;
        clr;
`else
        good(8'hF0);
        good(8'h1C);
        check("nobrk_count", count, 2);
        pop1;
        pop1;
`endif

        ticks(10);
        check("data_left", exp_data.size(), 0);
        check("err_left", exp_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver with an integrated first-word-fall-through scan-code FIFO. It synchronises and deglitches `kbd_clk`/`kbd_data`, deserialises 11-bit frames, and checks start, odd parity and stop bits. It aborts stalled frames on a watchdog and buffers good scan codes for the downstream consumer (UART bridge or CPU peripheral bus). It replaces the single-byte keyboard receiver in the top level and adds buffering, error reporting and break-code tagging.

## Interface
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: synchroniser flops on `kbd_clk` and `kbd_data`.
- `FILTER_LEN`, 4: consecutive equal synchronised `kbd_clk` samples required to change the filtered clock.
- `TIMEOUT_CYCLES`, 100000: `clk` cycles allowed between falling edges inside a frame.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `kbd_clk`  in  1  PS/2 clock, asynchronous.
- `kbd_data`  in  1  PS/2 data, asynchronous.
- `rd_en`  in  1  pop the head entry; ignored when `empty`.
- `clr_err`  in  1  clears `err_status`.
- `rd_data`  out  DW  head entry; DW = 9 with `PS2_BREAK_TAG_EN`, else 8.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `err_pulse`  out  4  one-cycle pulses {timeout, overflow, frame, parity}.
- `err_status`  out  4  sticky OR of `err_pulse`.

## Operation
- Front end: each input passes through SYNC_STAGES flops. Filtered clock `fclk` resets to 1 and changes only after FILTER_LEN equal samples. A falling edge of `fclk` raises a one-cycle `fall`. Data is sampled from synchronised `kbd_data` on `fall`.
- FSM: IDLE, SHIFT, CHECK.
  - IDLE: on `fall` with data=0 (start bit), go to SHIFT with bit counter 0. On `fall` with data=1, stay in IDLE with no error.
  - SHIFT: on each `fall`, shift data LSB-first into a 10-bit register (8 data, parity, stop) and increment the counter. After the 10th bit, go to CHECK.
  - CHECK (one cycle): if the stop bit is 0, pulse `frame`. Otherwise, if the XOR of data and parity is 0, pulse `parity`. Otherwise push the byte. Return to IDLE.
- Watchdog: the counter clears on every `fall` and counts only in SHIFT. At TIMEOUT_CYCLES it pulses `timeout`, discards the partial frame and returns to IDLE. It never triggers in IDLE.
- FIFO: a register array with read/write pointers that wrap modulo FIFO_DEPTH.
  - `rd_data` = mem[rd_ptr] whenever `!empty`; it holds its last value when empty.
  - Push while full with no pop in the same cycle: the byte is dropped and `overflow` pulses.
  - Push and pop in the same cycle while full: both happen, `count` is unchanged, no overflow.
  - Push and pop in the same cycle while empty: only the push happens.
- `err_status[i]` sets on `err_pulse[i]`. `clr_err` clears it. If a pulse and `clr_err` occur in the same cycle, set wins.
- Reset values: FSM IDLE, `fclk`=1, pointers 0, `count`=0, `empty`=1, `full`=0, `err_pulse`=0, `err_status`=0, `rd_data`=0. Reset mid-frame discards all state; the next start bit after reset release is received normally.

## Timing
- Input to `fall`: SYNC_STAGES + FILTER_LEN `clk` cycles after a `kbd_clk` falling edge.
- `fall` on the stop bit in cycle E gives CHECK in cycle E+1. The write lands at the end of E+1, so `empty`=0, `count` and `rd_data` update in E+2. Error pulses are asserted in E+1.
- `rd_en` in cycle P: `rd_data`/`count`/`empty` show the next entry in P+1.
- `full` asserts when `count`=FIFO_DEPTH. `count` reaches FIFO_DEPTH, never FIFO_DEPTH+1.

## Configuration
- `PS2_BREAK_TAG_EN` defined:
  - DW=9. A good byte 0xF0 is not pushed; it sets a `brk` flag.
  - The next good byte is pushed as {1, byte}, and `brk` clears.
  - `brk` also clears on any error, timeout or reset.
  - 0xF0 followed by 0xF0 pushes {1, 0xF0}.
- Undefined: DW=8, every good byte is pushed verbatim, and no `brk` logic exists.

## Test plan
- Frame start, 0x53, parity 1, stop at 10 kHz PS/2 clock, 100 MHz `clk` → `rd_data`=0x53, `count`=1, `err_status`=0. Then `rd_en` → `empty`=1.
- Same frame with parity 0 → `err_pulse`=4'b0001 for one cycle, `empty` stays 1. `clr_err` → `err_status`=0.
- Frame 0x53 with stop bit 0 → `err_pulse`=4'b0010. A following good 0x1C frame → `rd_data`=0x1C.
- Stop `kbd_clk` after 5 bits for TIMEOUT_CYCLES+10 → `err_pulse`=4'b1000 once, FSM IDLE. The next full 0x29 frame is received intact.
- FIFO_DEPTH+1 frames 0x00..0x10 with no pops → `full`=1, one overflow pulse, reads return 0x00..0x0F in order, and 0x10 is lost. Repeat with `rd_en` held on the last push → no overflow.
- With `PS2_BREAK_TAG_EN`: frames 0xF0, 0x1C → single entry 0x11C, `count`=1. Frames 0xF0, bad-parity frame, 0x1C → entry 0x01C.
